// File: rtl/stump_control.sv
`default_nettype none
// ============================================================================
// Module      : stump_control
// Description : Multi-cycle control unit for the Stump processor. Sequences
//               each instruction through FETCH, EXECUTE and MEMORY, decodes
//               the instruction register and evaluates branch conditions
//               against the NZVC flags. All outputs are combinational from
//               the state register, ir, cc and mem_wait.
//               Optional feature: define STUMP_MEM_WAIT_EN to let mem_wait
//               stall FETCH and MEMORY; otherwise mem_wait is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module stump_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  cc,
    input  logic        mem_wait,
    output logic [1:0]  state,
    output logic        ir_load,
    output logic        pc_inc,
    output logic [2:0]  func,
    output logic        opB_sel,
    output logic        ext8,
    output logic [1:0]  shift_op,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [2:0]  dest,
    output logic        reg_write,
    output logic        data_sel,
    output logic        cc_en,
    output logic        addr_en,
    output logic        mem_en,
    output logic        mem_wen
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_UNUSED  = 2'b11
    } state_t;

    localparam logic [2:0] c_OP_LDST  = 3'b110;
    localparam logic [2:0] c_OP_BCC   = 3'b111;
    localparam logic [2:0] c_FUNC_ADD = 3'b000;
    localparam logic [2:0] c_REG_PC   = 3'b111;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_stall;
    logic        w_cond_true;

    // Instruction fields
    logic [2:0]  w_opcode;
    logic        w_type;
    logic        w_s_store;
    logic [2:0]  w_dest;
    logic [2:0]  w_src_a;
    logic [2:0]  w_src_b;
    logic [1:0]  w_shift;
    logic [3:0]  w_cond;
    logic        w_n;
    logic        w_z;
    logic        w_v;
    logic        w_c;

    assign w_opcode  = ir[15:13];
    assign w_type    = ir[12];
    assign w_s_store = ir[11];
    assign w_dest    = ir[10:8];
    assign w_src_a   = ir[7:5];
    assign w_src_b   = ir[4:2];
    assign w_shift   = ir[1:0];
    assign w_cond    = ir[11:8];
    assign {w_n, w_z, w_v, w_c} = cc;

`ifdef STUMP_MEM_WAIT_EN
    assign w_stall = mem_wait;
`else
    // Port kept for pin compatibility; memory is always single-cycle here.
    logic w_unused_mem_wait;
    assign w_unused_mem_wait = mem_wait;
    assign w_stall           = 1'b0;
`endif

    assign state = r_state;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Branch condition evaluation against the current flags.
    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            4'h0:    w_cond_true = 1'b1;                      // AL
            4'h1:    w_cond_true = 1'b0;                      // NV
            4'h2:    w_cond_true = ~w_c & ~w_z;               // HI
            4'h3:    w_cond_true = w_c | w_z;                 // LS
            4'h4:    w_cond_true = ~w_c;                      // CC
            4'h5:    w_cond_true = w_c;                       // CS
            4'h6:    w_cond_true = ~w_z;                      // NE
            4'h7:    w_cond_true = w_z;                       // EQ
            4'h8:    w_cond_true = ~w_v;                      // VC
            4'h9:    w_cond_true = w_v;                       // VS
            4'hA:    w_cond_true = ~w_n;                      // PL
            4'hB:    w_cond_true = w_n;                       // MI
            4'hC:    w_cond_true = (w_n == w_v);              // GE
            4'hD:    w_cond_true = (w_n != w_v);              // LT
            4'hE:    w_cond_true = ~w_z & (w_n == w_v);       // GT
            default: w_cond_true = w_z | (w_n != w_v);        // LE
        endcase
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state = r_state;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        reg_write    = 1'b0;
        cc_en        = 1'b0;
        addr_en      = 1'b0;
        mem_en       = 1'b0;
        mem_wen      = 1'b0;
        func         = c_FUNC_ADD;
        opB_sel      = 1'b0;
        ext8         = 1'b0;
        shift_op     = 2'b00;
        srcA         = w_src_a;
        srcB         = w_src_b;
        dest         = w_dest;
        data_sel     = 1'b0;

        case (r_state)
            ST_FETCH: begin
                mem_en = 1'b1;
                // Write strobes fire only in the cycle memory delivers.
                if (!w_stall) begin
                    ir_load      = 1'b1;
                    pc_inc       = 1'b1;
                    w_next_state = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                if (w_opcode == c_OP_LDST) begin
                    // Effective address = srcA + offset, latched for MEMORY.
                    func         = c_FUNC_ADD;
                    opB_sel      = w_type;
                    shift_op     = w_type ? 2'b00 : w_shift;
                    addr_en      = 1'b1;
                    w_next_state = ST_MEMORY;
                end else if (w_opcode == c_OP_BCC) begin
                    // PC-relative target computed in the ALU, written only if taken.
                    func         = c_FUNC_ADD;
                    srcA         = c_REG_PC;
                    dest         = c_REG_PC;
                    opB_sel      = 1'b1;
                    ext8         = 1'b1;
                    reg_write    = w_cond_true;
                    w_next_state = ST_FETCH;
                end else begin
                    func         = w_opcode;
                    opB_sel      = w_type;
                    shift_op     = w_type ? 2'b00 : w_shift;
                    reg_write    = 1'b1;
                    cc_en        = w_s_store;
                    w_next_state = ST_FETCH;
                end
            end

            ST_MEMORY: begin
                mem_en   = 1'b1;
                data_sel = 1'b1;
                if (!w_stall) begin
                    mem_wen      = w_s_store;
                    reg_write    = ~w_s_store;
                    w_next_state = ST_FETCH;
                end
            end

            default: begin
                w_next_state = ST_FETCH;
            end
        endcase

        // Reset overrides every strobe so no write can leak out.
        if (rst) begin
            ir_load   = 1'b0;
            pc_inc    = 1'b0;
            reg_write = 1'b0;
            cc_en     = 1'b0;
            addr_en   = 1'b0;
            mem_en    = 1'b0;
            mem_wen   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stump_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_stump_control
// Description : Scoreboard bench for stump_control. The stimulus process
//               walks whole instructions (fetch, execute, memory) and pushes
//               the expected per-cycle control word; a monitor pops and
//               compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stump_control;

`ifdef STUMP_MEM_WAIT_EN
    localparam bit c_WAIT_EN = 1'b1;
`else
    localparam bit c_WAIT_EN = 1'b0;
`endif

    // Enable vector order: {ir_load, pc_inc, reg_write, cc_en, addr_en, mem_en, mem_wen}
    localparam logic [6:0] c_EN_IRL = 7'b1000000;
    localparam logic [6:0] c_EN_PCI = 7'b0100000;
    localparam logic [6:0] c_EN_RW  = 7'b0010000;
    localparam logic [6:0] c_EN_CC  = 7'b0001000;
    localparam logic [6:0] c_EN_AD  = 7'b0000100;
    localparam logic [6:0] c_EN_MEM = 7'b0000010;
    localparam logic [6:0] c_EN_WEN = 7'b0000001;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  cc;
    logic        mem_wait;
    logic [1:0]  state;
    logic        ir_load;
    logic        pc_inc;
    logic [2:0]  func;
    logic        opB_sel;
    logic        ext8;
    logic [1:0]  shift_op;
    logic [2:0]  srcA;
    logic [2:0]  srcB;
    logic [2:0]  dest;
    logic        reg_write;
    logic        data_sel;
    logic        cc_en;
    logic        addr_en;
    logic        mem_en;
    logic        mem_wen;

    stump_control dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .cc        (cc),
        .mem_wait  (mem_wait),
        .state     (state),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .func      (func),
        .opB_sel   (opB_sel),
        .ext8      (ext8),
        .shift_op  (shift_op),
        .srcA      (srcA),
        .srcB      (srcB),
        .dest      (dest),
        .reg_write (reg_write),
        .data_sel  (data_sel),
        .cc_en     (cc_en),
        .addr_en   (addr_en),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         c_st;   logic [1:0] st;
        logic [6:0] en;
        bit         c_func; logic [2:0] func;
        bit         c_opb;  logic       opb;
        bit         c_ext8; logic       ext8;
        bit         c_shf;  logic [1:0] shf;
        bit         c_srca; logic [2:0] srca;
        bit         c_srcb; logic [2:0] srcb;
        bit         c_dest; logic [2:0] dest;
        bit         c_dsel; logic       dsel;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stim_done = 1'b0;

    function automatic exp_t blank();
        exp_t e;
        e.c_st = 0;   e.st = 2'b00; e.en = 7'b0;
        e.c_func = 0; e.func = 3'b0; e.c_opb = 0; e.opb = 1'b0;
        e.c_ext8 = 0; e.ext8 = 1'b0; e.c_shf = 0; e.shf = 2'b0;
        e.c_srca = 0; e.srca = 3'b0; e.c_srcb = 0; e.srcb = 3'b0;
        e.c_dest = 0; e.dest = 3'b0; e.c_dsel = 0; e.dsel = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Branch conditions come in complementary pairs: the even code is the
    // base predicate, the odd code its inverse.
    function automatic bit branch_taken(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, v, c, base;
        {n, z, v, c} = f;
        case (cond >> 1)
            0: base = 1;
            1: base = !c && !z;
            2: base = !c;
            3: base = !z;
            4: base = !v;
            5: base = !n;
            6: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ cond[0];
    endfunction

    task automatic drive(input logic r, input logic [15:0] i, input logic [3:0] c,
                         input logic w, input exp_t e);
        rst = r; ir = i; cc = c; mem_wait = w;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Fetch phase: fw cycles requested with mem_wait high, then memory delivers.
    task automatic do_fetch(input logic [15:0] i, input logic [3:0] c, input int fw);
        int   k;
        bit   w;
        bit   stall;
        exp_t e;
        k = 0;
        do begin
            w     = (k < fw);
            stall = c_WAIT_EN && w;
            e       = blank();
            e.c_st  = 1; e.st = 2'd0;
            e.en    = stall ? c_EN_MEM : (c_EN_IRL | c_EN_PCI | c_EN_MEM);
            drive(1'b0, i, c, w, e);
            k++;
        end while (stall);
    endtask

    task automatic do_execute(input logic [15:0] i, input logic [3:0] c);
        exp_t        e;
        logic [2:0]  op;
        op = i[15:13];
        e = blank();
        e.c_st = 1; e.st = 2'd1;
        e.c_func = 1; e.func = 3'd0;
        if (op <= 3'd5) begin
            e.en   = c_EN_RW | (i[11] ? c_EN_CC : 7'b0);
            e.func = op;
            e.c_opb = 1; e.opb = i[12];
            e.c_shf = 1; e.shf = i[12] ? 2'b00 : i[1:0];
            e.c_srca = 1; e.srca = i[7:5];
            e.c_srcb = !i[12]; e.srcb = i[4:2];
            e.c_dest = 1; e.dest = i[10:8];
        end else if (op == 3'd6) begin
            e.en   = c_EN_AD;
            e.c_opb = 1; e.opb = i[12];
            e.c_srca = 1; e.srca = i[7:5];
        end else begin
            e.en   = branch_taken(i[11:8], c) ? c_EN_RW : 7'b0;
            e.c_opb = 1; e.opb = 1'b1;
            e.c_ext8 = 1; e.ext8 = 1'b1;
            e.c_srca = 1; e.srca = 3'd7;
            e.c_dest = 1; e.dest = 3'd7;
        end
        drive(1'b0, i, c, $urandom_range(0, 1), e);
    endtask

    task automatic do_memory(input logic [15:0] i, input logic [3:0] c, input int mw);
        int   k;
        bit   w;
        bit   stall;
        exp_t e;
        k = 0;
        do begin
            w     = (k < mw);
            stall = c_WAIT_EN && w;
            e = blank();
            e.c_st = 1; e.st = 2'd2;
            if (stall)      e.en = c_EN_MEM;
            else if (i[11]) e.en = c_EN_MEM | c_EN_WEN;
            else            e.en = c_EN_MEM | c_EN_RW;
            if (!i[11]) begin
                e.c_dsel = 1; e.dsel = 1'b1;
                e.c_dest = 1; e.dest = i[10:8];
            end
            drive(1'b0, i, c, w, e);
            k++;
        end while (stall);
    endtask

    task automatic do_instr(input logic [15:0] i, input logic [3:0] c, input int fw, input int mw);
        do_fetch(i, c, fw);
        do_execute(i, c);
        if (i[15:13] == 3'd6) do_memory(i, c, mw);
    endtask

    task automatic reset_cycle(input logic [15:0] i, input bit know_st, input logic [1:0] st);
        exp_t e;
        e = blank();
        e.c_st = know_st; e.st = st;
        drive(1'b1, i, 4'h0, 1'b0, e);
    endtask

    // Stimulus: directed cases first, then random instruction stream.
    initial begin
        exp_t e;
        logic [15:0] ri;
        rst = 1'b1; ir = 16'h0; cc = 4'h0; mem_wait = 1'b0;
        @(posedge clk);
        #1;
        reset_cycle(16'h0, 1, 2'd0);

        do_instr(16'h0A2C, 4'h0, 0, 0);              // ADDS R2,R1,R3
        do_instr(16'hD143, 4'h0, 0, 0);              // LD R1,[R2,#3]
        do_instr(16'hD943, 4'h0, 0, 0);              // ST
        do_instr(16'hE7FE, 4'b0100, 0, 0);           // BEQ taken
        do_instr(16'hE7FE, 4'b0000, 0, 0);           // BEQ not taken
        do_instr(16'hEE05, 4'b1010, 0, 0);           // BGT taken
        do_instr(16'h0A2C, 4'h0, 3, 0);              // fetch stall of 3
        do_instr(16'hD143, 4'h0, 1, 2);              // load with both stalls

        // Reset while in MEMORY of a store: no write may escape.
        do_fetch(16'hD943, 4'h0, 0);
        do_execute(16'hD943, 4'h0);
        reset_cycle(16'hD943, 1, 2'd2);
        reset_cycle(16'hD943, 1, 2'd0);
        do_instr(16'h0A2C, 4'h0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            ri = 16'($urandom);
            do_instr(ri, 4'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        e = blank();
        stim_done = 1'b1;
    end

    // Monitor: compare DUT outputs against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                if (m_e.c_st) chk("state", 32'(state), 32'(m_e.st));
                chk("enables", 32'({ir_load, pc_inc, reg_write, cc_en, addr_en, mem_en, mem_wen}),
                    32'(m_e.en));
                if (m_e.c_func) chk("func", 32'(func), 32'(m_e.func));
                if (m_e.c_opb)  chk("opB_sel", 32'(opB_sel), 32'(m_e.opb));
                if (m_e.c_ext8) chk("ext8", 32'(ext8), 32'(m_e.ext8));
                if (m_e.c_shf)  chk("shift_op", 32'(shift_op), 32'(m_e.shf));
                if (m_e.c_srca) chk("srcA", 32'(srcA), 32'(m_e.srca));
                if (m_e.c_srcb) chk("srcB", 32'(srcB), 32'(m_e.srcb));
                if (m_e.c_dest) chk("dest", 32'(dest), 32'(m_e.dest));
                if (m_e.c_dsel) chk("data_sel", 32'(data_sel), 32'(m_e.dsel));
            end
        end
    end

    // Completion and watchdog.
    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        if (!stim_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", budget);
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
